// File: rtl/cp0_tlb_ctrl_if.sv
// TLB instruction handshake plus the MMU request/response bundle.
// master = CP0-side controller, slave = execute stage / MMU side.
interface cp0_tlb_ctrl_if #(
   parameter int IW = 4
);
   logic          op_valid;
   logic [1:0]    op_code;
   logic          op_ready;
   logic          op_done;
   logic [7:0]    mmu_asid;
   logic          mmu_is_tlbwi;
   logic          mmu_is_tlbwr;
   logic [IW-1:0] mmu_index;
   logic [IW-1:0] mmu_random;
   logic [31:0]   mmu_entry_hi;
   logic [31:0]   mmu_entry_lo0;
   logic [31:0]   mmu_entry_lo1;
   logic [31:0]   mmu_p_index;
   logic [31:0]   mmu_r_hi;
   logic [31:0]   mmu_r_lo0;
   logic [31:0]   mmu_r_lo1;

   modport master (
      input  op_valid, op_code, mmu_p_index, mmu_r_hi, mmu_r_lo0, mmu_r_lo1,
      output op_ready, op_done, mmu_asid, mmu_is_tlbwi, mmu_is_tlbwr, mmu_index,
             mmu_random, mmu_entry_hi, mmu_entry_lo0, mmu_entry_lo1
   );

   modport slave (
      output op_valid, op_code, mmu_p_index, mmu_r_hi, mmu_r_lo0, mmu_r_lo1,
      input  op_ready, op_done, mmu_asid, mmu_is_tlbwi, mmu_is_tlbwr, mmu_index,
             mmu_random, mmu_entry_hi, mmu_entry_lo0, mmu_entry_lo1
   );
endinterface

// File: rtl/cp0_tlb_ctrl.sv
// CP0 TLB register file and TLBR/TLBWI/TLBWR/TLBP sequencer towards the MMU.
// Snapshots of Index/Random/EntryHi/EntryLo are taken when an op is accepted
// and held until the next accept; MTC0 during an op only touches the
// architectural copies.
module cp0_tlb_ctrl #(
   parameter int  TLB_ENTRIES = 16,
   localparam int IW          = $clog2(TLB_ENTRIES)
) (
   input  logic           clk,
   input  logic           resetn,
   cp0_tlb_ctrl_if.master bus,
   input  logic           cp0_we,
   input  logic [4:0]     cp0_waddr,
   input  logic [31:0]    cp0_wdata,
   input  logic [4:0]     cp0_raddr,
   output logic [31:0]    cp0_rdata,
   input  logic           exc_tlb,
   input  logic [31:0]    exc_badvaddr
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WRITE   = 2'd1,
      ST_LOOKUP  = 2'd2,
      ST_CAPTURE = 2'd3
   } state_t;

   localparam logic [1:0] OP_TLBR  = 2'b00;
   localparam logic [1:0] OP_TLBWI = 2'b01;
   localparam logic [1:0] OP_TLBWR = 2'b10;
   localparam logic [1:0] OP_TLBP  = 2'b11;

   localparam logic [4:0] REG_INDEX    = 5'd0;
   localparam logic [4:0] REG_RANDOM   = 5'd1;
   localparam logic [4:0] REG_ENTRYLO0 = 5'd2;
   localparam logic [4:0] REG_ENTRYLO1 = 5'd3;
   localparam logic [4:0] REG_CONTEXT  = 5'd4;
   localparam logic [4:0] REG_WIRED    = 5'd6;
   localparam logic [4:0] REG_ENTRYHI  = 5'd10;

   localparam logic [IW-1:0] RANDOM_MAX = IW'(TLB_ENTRIES - 1);

   state_t        state_r;
   state_t        state_nxt_s;
   logic [1:0]    op_r;

   logic          index_p_r;
   logic [IW-1:0] index_r;
   logic [IW-1:0] random_r;
   logic [IW-1:0] wired_r;
   logic [25:0]   lo0_r;
   logic [25:0]   lo1_r;
   logic [8:0]    pte_base_r;
   logic [18:0]   bad_vpn2_r;
   logic [18:0]   vpn2_r;
   logic [7:0]    asid_r;

   logic [IW-1:0] snap_index_r;
   logic [IW-1:0] snap_random_r;
   logic [31:0]   snap_hi_r;
   logic [31:0]   snap_lo0_r;
   logic [31:0]   snap_lo1_r;

   logic          accept_s;
   logic          ready_s;
   logic          op_done_s;
   logic          tlbwi_s;
   logic          tlbwr_s;
   logic          capture_s;
   logic [31:0]   entry_hi_s;
   logic [31:0]   rdata_s;

   logic          wr_index_s;
   logic          wr_lo0_s;
   logic          wr_lo1_s;
   logic          wr_context_s;
   logic          wr_wired_s;
   logic          wr_hi_s;
   logic          unused_s;

   assign wr_index_s   = cp0_we && (cp0_waddr == REG_INDEX);
   assign wr_lo0_s     = cp0_we && (cp0_waddr == REG_ENTRYLO0);
   assign wr_lo1_s     = cp0_we && (cp0_waddr == REG_ENTRYLO1);
   assign wr_context_s = cp0_we && (cp0_waddr == REG_CONTEXT);
   assign wr_wired_s   = cp0_we && (cp0_waddr == REG_WIRED);
   assign wr_hi_s      = cp0_we && (cp0_waddr == REG_ENTRYHI);

   assign entry_hi_s = {vpn2_r, 5'd0, asid_r};

   // Next-state and per-state strobes; exceptions abort lookups and block accepts.
   always_comb begin
      state_nxt_s = state_r;
      accept_s    = 1'b0;
      ready_s     = 1'b0;
      op_done_s   = 1'b0;
      tlbwi_s     = 1'b0;
      tlbwr_s     = 1'b0;
      capture_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            ready_s = !exc_tlb;
            if (bus.op_valid && !exc_tlb) begin
               accept_s = 1'b1;
               if ((bus.op_code == OP_TLBWI) || (bus.op_code == OP_TLBWR)) begin
                  state_nxt_s = ST_WRITE;
               end else begin
                  state_nxt_s = ST_LOOKUP;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_WRITE: begin
            op_done_s   = 1'b1;
            tlbwi_s     = (op_r == OP_TLBWI);
            tlbwr_s     = (op_r == OP_TLBWR);
            state_nxt_s = ST_IDLE;
         end
         ST_LOOKUP: begin
            if (exc_tlb) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_CAPTURE;
            end
         end
         ST_CAPTURE: begin
            if (!exc_tlb) begin
               capture_s = 1'b1;
               op_done_s = 1'b1;
            end else begin
               capture_s = 1'b0;
            end
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // FSM state and the opcode of the op in flight.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r <= ST_IDLE;
         op_r    <= 2'b00;
      end else begin
         state_r <= state_nxt_s;
         if (accept_s) begin
            op_r <= bus.op_code;
         end
      end
   end

   // Random countdown, reloaded at Wired or zero and on any Wired write.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         random_r <= RANDOM_MAX;
      end else if (wr_wired_s) begin
         random_r <= RANDOM_MAX;
      end else if ((random_r == wired_r) || (random_r == {IW{1'b0}})) begin
         random_r <= RANDOM_MAX;
      end else begin
         random_r <= random_r - IW'(1);
      end
   end

   // Index: TLBP result wins over a same-cycle MTC0; P is hardware-only.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         index_p_r <= 1'b0;
         index_r   <= {IW{1'b0}};
      end else if (capture_s && (op_r == OP_TLBP)) begin
         index_p_r <= bus.mmu_p_index[31];
         index_r   <= bus.mmu_p_index[IW-1:0];
      end else if (wr_index_s) begin
         index_r <= cp0_wdata[IW-1:0];
      end
   end

   // EntryLo0/1: TLBR capture wins over a same-cycle MTC0.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         lo0_r <= 26'd0;
         lo1_r <= 26'd0;
      end else if (capture_s && (op_r == OP_TLBR)) begin
         lo0_r <= bus.mmu_r_lo0[25:0];
         lo1_r <= bus.mmu_r_lo1[25:0];
      end else begin
         if (wr_lo0_s) begin
            lo0_r <= cp0_wdata[25:0];
         end
         if (wr_lo1_s) begin
            lo1_r <= cp0_wdata[25:0];
         end
      end
   end

   // EntryHi: exception VPN2 first, then TLBR capture, then MTC0.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         vpn2_r <= 19'd0;
         asid_r <= 8'd0;
      end else begin
         if (exc_tlb) begin
            vpn2_r <= exc_badvaddr[31:13];
         end else if (capture_s && (op_r == OP_TLBR)) begin
            vpn2_r <= bus.mmu_r_hi[31:13];
         end else if (wr_hi_s) begin
            vpn2_r <= cp0_wdata[31:13];
         end
         if (capture_s && (op_r == OP_TLBR)) begin
            asid_r <= bus.mmu_r_hi[7:0];
         end else if (wr_hi_s) begin
            asid_r <= cp0_wdata[7:0];
         end
      end
   end

   // Context (PTEBase by MTC0, BadVPN2 by exception only) and Wired.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pte_base_r <= 9'd0;
         bad_vpn2_r <= 19'd0;
         wired_r    <= {IW{1'b0}};
      end else begin
         if (wr_context_s) begin
            pte_base_r <= cp0_wdata[31:23];
         end
         if (exc_tlb) begin
            bad_vpn2_r <= exc_badvaddr[31:13];
         end
         if (wr_wired_s) begin
            wired_r <= cp0_wdata[IW-1:0];
         end
      end
   end

   // Operand snapshots presented to the MMU, refreshed only on accept.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         snap_index_r  <= {IW{1'b0}};
         snap_random_r <= {IW{1'b0}};
         snap_hi_r     <= 32'd0;
         snap_lo0_r    <= 32'd0;
         snap_lo1_r    <= 32'd0;
      end else if (accept_s) begin
         snap_index_r  <= index_r;
         snap_random_r <= random_r;
         snap_hi_r     <= entry_hi_s;
         snap_lo0_r    <= {6'd0, lo0_r};
         snap_lo1_r    <= {6'd0, lo1_r};
      end
   end

   // MFC0 read mux over pre-write register state.
   always_comb begin
      rdata_s = 32'd0;
      case (cp0_raddr)
         REG_INDEX: begin
            rdata_s[IW-1:0] = index_r;
            rdata_s[31]     = index_p_r;
         end
         REG_RANDOM:   rdata_s[IW-1:0] = random_r;
         REG_ENTRYLO0: rdata_s = {6'd0, lo0_r};
         REG_ENTRYLO1: rdata_s = {6'd0, lo1_r};
         REG_CONTEXT:  rdata_s = {pte_base_r, bad_vpn2_r, 4'd0};
         REG_WIRED:    rdata_s[IW-1:0] = wired_r;
         REG_ENTRYHI:  rdata_s = entry_hi_s;
         default:      rdata_s = 32'd0;
      endcase
   end

   assign cp0_rdata          = rdata_s;
   assign bus.op_ready       = ready_s;
   assign bus.op_done        = op_done_s;
   assign bus.mmu_is_tlbwi   = tlbwi_s;
   assign bus.mmu_is_tlbwr   = tlbwr_s;
   assign bus.mmu_asid       = asid_r;
   assign bus.mmu_index      = snap_index_r;
   assign bus.mmu_random     = snap_random_r;
   assign bus.mmu_entry_hi   = snap_hi_r;
   assign bus.mmu_entry_lo0  = snap_lo0_r;
   assign bus.mmu_entry_lo1  = snap_lo1_r;

   // Response bits outside the architected fields are intentionally dropped.
   assign unused_s = ^{bus.mmu_r_hi[12:8], bus.mmu_r_lo0[31:26], bus.mmu_r_lo1[31:26],
                       bus.mmu_p_index[30:IW], exc_badvaddr[12:0]};

endmodule

// File: tb/tb_cp0_tlb_ctrl.sv
// Randomised bench for cp0_tlb_ctrl: a cycle-level reference model of the CP0
// registers checks every read and op_ready; completed ops are matched against
// a queue of expected completions by an independent monitor.
module tb_cp0_tlb_ctrl;

   typedef struct {
      logic [1:0]  op;
      int          done_cyc;
      logic [3:0]  idx;
      logic [3:0]  rnd;
      logic [31:0] hi;
      logic [31:0] lo0;
      logic [31:0] lo1;
   } exp_t;

   logic        clk;
   logic        resetn;
   logic        cp0_we;
   logic [4:0]  cp0_waddr;
   logic [31:0] cp0_wdata;
   logic [4:0]  cp0_raddr;
   logic [31:0] cp0_rdata;
   logic        exc_tlb;
   logic [31:0] exc_badvaddr;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   exp_t q[$];

   // reference model state
   logic        m_index_p;
   logic [3:0]  m_index;
   logic [3:0]  m_wired;
   int          m_random;
   logic [25:0] m_lo0;
   logic [25:0] m_lo1;
   logic [8:0]  m_pte;
   logic [18:0] m_badvpn2;
   logic [18:0] m_vpn2;
   logic [7:0]  m_asid;
   bit          m_busy;
   int          m_age;
   logic [1:0]  m_op;

   cp0_tlb_ctrl_if #(.IW(4)) bus ();

   cp0_tlb_ctrl #(.TLB_ENTRIES(16)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .bus          (bus),
      .cp0_we       (cp0_we),
      .cp0_waddr    (cp0_waddr),
      .cp0_wdata    (cp0_wdata),
      .cp0_raddr    (cp0_raddr),
      .cp0_rdata    (cp0_rdata),
      .exc_tlb      (exc_tlb),
      .exc_badvaddr (exc_badvaddr)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] m_read(input logic [4:0] a);
      logic [3:0] r4;
      r4 = 4'(m_random);
      case (a)
         5'd0:    return {m_index_p, 27'd0, m_index};
         5'd1:    return {28'd0, r4};
         5'd2:    return {6'd0, m_lo0};
         5'd3:    return {6'd0, m_lo1};
         5'd4:    return {m_pte, m_badvpn2, 4'd0};
         5'd6:    return {28'd0, m_wired};
         5'd10:   return {m_vpn2, 5'd0, m_asid};
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_reset();
      m_index_p = 1'b0; m_index = 4'd0; m_wired = 4'd0; m_random = 15;
      m_lo0 = 26'd0; m_lo1 = 26'd0; m_pte = 9'd0; m_badvpn2 = 19'd0;
      m_vpn2 = 19'd0; m_asid = 8'd0; m_busy = 1'b0; m_age = 0; m_op = 2'd0;
   endtask

   task automatic model_step();
      int   nr;
      bit   is_lookup;
      bit   do_capture;
      bit   is_write_op;
      exp_t e;
      if (cp0_we && cp0_waddr == 5'd6) nr = 15;
      else if (m_random == int'(m_wired) || m_random == 0) nr = 15;
      else nr = m_random - 1;
      is_lookup  = m_busy && (m_op == 2'd0 || m_op == 2'd3);
      do_capture = is_lookup && (m_age == 2) && !exc_tlb;
      if (is_lookup && exc_tlb && q.size() != 0) q.delete(q.size() - 1);
      if (!m_busy && bus.op_valid && !exc_tlb) begin
         is_write_op = (bus.op_code == 2'd1) || (bus.op_code == 2'd2);
         e.op       = bus.op_code;
         e.done_cyc = cyc + (is_write_op ? 1 : 2);
         e.idx      = m_index;
         e.rnd      = 4'(m_random);
         e.hi       = m_read(5'd10);
         e.lo0      = {6'd0, m_lo0};
         e.lo1      = {6'd0, m_lo1};
         q.push_back(e);
      end
      if (cp0_we) begin
         case (cp0_waddr)
            5'd0:  m_index = cp0_wdata[3:0];
            5'd2:  m_lo0 = cp0_wdata[25:0];
            5'd3:  m_lo1 = cp0_wdata[25:0];
            5'd4:  m_pte = cp0_wdata[31:23];
            5'd6:  m_wired = cp0_wdata[3:0];
            5'd10: begin m_vpn2 = cp0_wdata[31:13]; m_asid = cp0_wdata[7:0]; end
            default: ;
         endcase
      end
      if (do_capture) begin
         if (m_op == 2'd3) begin
            m_index_p = bus.mmu_p_index[31];
            m_index   = bus.mmu_p_index[3:0];
         end else begin
            m_vpn2 = bus.mmu_r_hi[31:13];
            m_asid = bus.mmu_r_hi[7:0];
            m_lo0  = bus.mmu_r_lo0[25:0];
            m_lo1  = bus.mmu_r_lo1[25:0];
         end
      end
      if (exc_tlb) begin
         m_vpn2    = exc_badvaddr[31:13];
         m_badvpn2 = exc_badvaddr[31:13];
      end
      m_random = nr;
      if (m_busy) begin
         if (m_op == 2'd1 || m_op == 2'd2 || m_age == 2 || exc_tlb) m_busy = 1'b0;
         else m_age = 2;
      end else if (bus.op_valid && !exc_tlb) begin
         m_busy = 1'b1;
         m_age  = 1;
         m_op   = bus.op_code;
      end
   endtask

   // model: check architectural view every cycle, then advance one edge
   initial begin
      forever begin
         @(negedge clk);
         if (!resetn) begin
            model_reset();
            q.delete();
         end else begin
            chk("rdata", cp0_rdata, m_read(cp0_raddr));
            chk("op_ready", {31'd0, bus.op_ready}, {31'd0, (!m_busy && !exc_tlb)});
            chk("mmu_asid", {24'd0, bus.mmu_asid}, {24'd0, m_asid});
            model_step();
         end
      end
   end

   // monitor: match each completion against the expected-response queue
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (!resetn) begin
            chk("reset_quiet", {29'd0, bus.op_done, bus.mmu_is_tlbwi, bus.mmu_is_tlbwr}, 32'd0);
         end else if (bus.op_done === 1'b1) begin
            if (q.size() == 0) begin
               total++; bad++;
               $display("FAIL spurious_done: got op_done=1 expected no op pending (cycle %0d)", cyc);
            end else begin
               e = q.pop_front();
               chk("done_cycle", cyc, e.done_cyc);
               chk("tlbwi", {31'd0, bus.mmu_is_tlbwi}, {31'd0, (e.op == 2'd1)});
               chk("tlbwr", {31'd0, bus.mmu_is_tlbwr}, {31'd0, (e.op == 2'd2)});
               chk("snap_index", {28'd0, bus.mmu_index}, {28'd0, e.idx});
               chk("snap_random", {28'd0, bus.mmu_random}, {28'd0, e.rnd});
               chk("snap_hi", bus.mmu_entry_hi, e.hi);
               chk("snap_lo0", bus.mmu_entry_lo0, e.lo0);
               chk("snap_lo1", bus.mmu_entry_lo1, e.lo1);
            end
         end else begin
            chk("strobe_idle", {30'd0, bus.mmu_is_tlbwi, bus.mmu_is_tlbwr}, 32'd0);
            if (q.size() != 0 && q[0].done_cyc <= cyc) begin
               total++; bad++;
               $display("FAIL missing_done: got op_done=0 expected 1 (cycle %0d)", cyc);
               e = q.pop_front();
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
      cp0_we = 1'b1; cp0_waddr = a; cp0_wdata = d;
      tick();
      cp0_we = 1'b0;
   endtask

   task automatic issue(input logic [1:0] code);
      bus.op_valid = 1'b1; bus.op_code = code;
      tick();
      bus.op_valid = 1'b0;
   endtask

   task automatic rd_chk(input string name, input logic [4:0] a, input logic [31:0] mask,
                         input logic [31:0] exp);
      cp0_raddr = a;
      @(negedge clk);
      chk(name, cp0_rdata & mask, exp);
      tick();
   endtask

   function automatic logic [4:0] pick_reg(input int k);
      case (k)
         0: return 5'd0;  1: return 5'd1;  2: return 5'd2;
         3: return 5'd3;  4: return 5'd4;  5: return 5'd5;
         6: return 5'd6;  7: return 5'd10; default: return 5'd15;
      endcase
   endfunction

   initial begin
      resetn = 1'b0; cp0_we = 1'b0; cp0_waddr = 5'd0; cp0_wdata = 32'd0;
      cp0_raddr = 5'd1; exc_tlb = 1'b0; exc_badvaddr = 32'd0;
      bus.op_valid = 1'b0; bus.op_code = 2'd0; bus.mmu_p_index = 32'd0;
      bus.mmu_r_hi = 32'd0; bus.mmu_r_lo0 = 32'd0; bus.mmu_r_lo1 = 32'd0;
      repeat (3) tick();
      resetn = 1'b1;
      @(negedge clk);
      chk("rst_snap_hi", bus.mmu_entry_hi, 32'd0);
      chk("rst_snap_index", {28'd0, bus.mmu_index}, 32'd0);
      chk("rst_random", cp0_rdata, 32'd15);
      tick();
      repeat (20) tick();

      mtc0(5'd6, 32'd4);
      rd_chk("random_after_wired", 5'd1, 32'hFFFF_FFFF, 32'd15);
      cp0_raddr = 5'd1;
      repeat (20) tick();

      mtc0(5'd0, 32'd3);
      mtc0(5'd10, 32'h8000_2005);
      mtc0(5'd2, 32'h0123_4567);
      mtc0(5'd3, 32'hFFFF_FFFF);
      issue(2'd1);
      repeat (3) tick();

      bus.mmu_p_index = 32'h8000_0000;
      issue(2'd3);
      repeat (2) tick();
      rd_chk("tlbp_miss", 5'd0, 32'hFFFF_FFFF, 32'h8000_0000);
      bus.mmu_p_index = 32'h0000_0007;
      issue(2'd3);
      repeat (2) tick();
      rd_chk("tlbp_hit", 5'd0, 32'hFFFF_FFFF, 32'h0000_0007);

      bus.mmu_r_hi = 32'h1234_6042; bus.mmu_r_lo0 = 32'h0123_4567; bus.mmu_r_lo1 = 32'h0FED_CBA9;
      issue(2'd0);
      mtc0(5'd2, 32'h55);
      mtc0(5'd2, 32'h66);
      rd_chk("tlbr_lo0", 5'd2, 32'hFFFF_FFFF, 32'h0123_4567);
      rd_chk("tlbr_hi", 5'd10, 32'hFFFF_FFFF, 32'h1234_6042);

      issue(2'd0);
      exc_tlb = 1'b1; exc_badvaddr = 32'h7FFF_E123;
      tick();
      exc_tlb = 1'b0;
      rd_chk("exc_vpn2", 5'd10, 32'hFFFF_E000, 32'h7FFF_E000);
      rd_chk("exc_badvpn2", 5'd4, 32'h007F_FFF0, 32'h003F_FFF0);

      issue(2'd0);
      resetn = 1'b0;
      repeat (2) tick();
      resetn = 1'b1;
      repeat (3) tick();

      repeat (3000) begin
         bus.op_valid = ($urandom_range(2) == 0);
         bus.op_code  = 2'($urandom_range(3));
         cp0_we       = ($urandom_range(3) == 0);
         cp0_waddr    = pick_reg($urandom_range(8));
         cp0_wdata    = $urandom;
         cp0_raddr    = pick_reg($urandom_range(8));
         exc_tlb      = ($urandom_range(15) == 0);
         exc_badvaddr = $urandom;
         if (exc_tlb && (cp0_waddr == 5'd4 || cp0_waddr == 5'd10)) cp0_we = 1'b0;
         bus.mmu_p_index = $urandom;
         bus.mmu_r_hi    = $urandom;
         bus.mmu_r_lo0   = $urandom;
         bus.mmu_r_lo1   = $urandom;
         tick();
      end
      bus.op_valid = 1'b0; cp0_we = 1'b0; exc_tlb = 1'b0;
      repeat (5) tick();
      chk("drain", q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cp0_tlb_ctrl.md
Name: cp0_tlb_ctrl

Overview:
- CP0-side initiator of the TLB instruction interface.
- Holds the TLB-related CP0 registers: Index, Random, EntryLo0, EntryLo1, Context, Wired, EntryHi.
- Sequences TLBR/TLBWI/TLBWR/TLBP against the MMU through a small FSM, captures MMU responses, and applies TLB-exception side effects (BadVPN2, EntryHi.VPN2).
- Sits between the CP0/execute stage and the MMU's TLB request/response ports.

Parameters:
TLB_ENTRIES, 16, number of TLB entries; index width IW = log2(TLB_ENTRIES)

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
op_valid  in  1  TLB instruction request
op_code  in  2  00 TLBR, 01 TLBWI, 10 TLBWR, 11 TLBP
op_ready  out  1  high only in IDLE
op_done  out  1  one-cycle completion pulse
cp0_we  in  1  MTC0 write strobe
cp0_waddr  in  5  CP0 register number
cp0_wdata  in  32  MTC0 data
cp0_raddr  in  5  MFC0 register number
cp0_rdata  out  32  combinational read data (0 for unlisted numbers)
exc_tlb  in  1  TLB refill/invalid/modified exception commit
exc_badvaddr  in  32  faulting virtual address
mmu_asid  out  8  live EntryHi.ASID used for translation
mmu_is_tlbwi  out  1  write strobe, indexed
mmu_is_tlbwr  out  1  write strobe, random
mmu_index  out  IW  snapshot Index.index
mmu_random  out  IW  snapshot Random
mmu_entry_hi  out  32  snapshot EntryHi
mmu_entry_lo0  out  32  snapshot EntryLo0
mmu_entry_lo1  out  32  snapshot EntryLo1
mmu_p_index  in  32  TLBP result: bit31 = P, [IW-1:0] = index
mmu_r_hi  in  32  TLBR read data, EntryHi format
mmu_r_lo0  in  32  TLBR read data, EntryLo0 format
mmu_r_lo1  in  32  TLBR read data, EntryLo1 format

Behaviour:
- Register numbers: 0 Index, 1 Random, 2 EntryLo0, 3 EntryLo1, 4 Context, 6 Wired, 10 EntryHi.
- Register fields:
  - Index: P[31] (written only by TLBP), index[IW-1:0].
  - EntryHi: VPN2[31:13], ASID[7:0].
  - EntryLo: PFN[25:6], C[5:3], D[2], V[1], G[0].
  - Context: PTEBase[31:23] (MTC0-writable), BadVPN2[22:4] (hardware-only).
  - Wired: [IW-1:0].
  - All other bits read 0 and ignore writes.
- Reset values:
  - All registers 0, except Random = TLB_ENTRIES-1.
  - FSM in IDLE; op_done = 0; write strobes = 0; snapshots = 0.
- Random:
  - Every cycle: if Random == Wired, or Random == 0, next = TLB_ENTRIES-1; otherwise next = Random - 1.
  - Any MTC0 to Wired forces Random = TLB_ENTRIES-1 on the next cycle.
  - Random is read-only to MTC0.
  - If Wired == TLB_ENTRIES-1, Random holds TLB_ENTRIES-1.
- FSM states: IDLE, WRITE, LOOKUP, CAPTURE.
- IDLE:
  - op_valid accepted when op_ready is high.
  - On accept, snapshot Index.index, Random, EntryHi, EntryLo0, EntryLo1 into the mmu_* outputs.
  - TLBWI/TLBWR go to WRITE; TLBR/TLBP go to LOOKUP.
- WRITE:
  - Exactly one cycle of mmu_is_tlbwi or mmu_is_tlbwr (per op), with op_done = 1.
  - Returns to IDLE. Latency: done 1 cycle after accept.
- LOOKUP:
  - Snapshots held.
  - The MMU returns registered results one cycle later.
  - Goes to CAPTURE.
- CAPTURE:
  - TLBP: Index ← {mmu_p_index[31], 0, mmu_p_index[IW-1:0]}.
  - TLBR: EntryHi ← mmu_r_hi; EntryLo0 ← mmu_r_lo0; EntryLo1 ← mmu_r_lo1.
  - op_done = 1; return to IDLE. Latency: done 2 cycles after accept.
- MTC0 while busy:
  - Updates the architectural register; never changes the snapshots.
  - A CAPTURE write beats a same-cycle MTC0 to the same register.
- exc_tlb:
  - EntryHi.VPN2 ← exc_badvaddr[31:13]; Context.BadVPN2 ← exc_badvaddr[31:13].
  - Priority over same-cycle MTC0 to EntryHi or Context.
  - In LOOKUP or CAPTURE: abort to IDLE with no register capture and no op_done.
  - In WRITE: the write strobe and op_done still occur.
- Simultaneous exc_tlb and op_valid in IDLE: op not accepted (op_ready forced low that cycle).
- Reset asserted mid-operation: immediate return to IDLE, strobes low, no op_done.
- cp0_rdata reflects register state before the current cycle's writes (no bypass).

Test Plan:
- Reset, then idle 20 cycles -> Random sequence 15,14,…,0,15,14,13,12; op_ready = 1; cp0_rdata(1) tracks it.
- MTC0 Wired = 4 -> next cycle Random = 15; Random counts down to 4 then wraps to 15, never below 4.
- MTC0 Index = 3, EntryHi = 0x80002005, EntryLo0/1; TLBWI -> one-cycle mmu_is_tlbwi with mmu_index = 3 and snapshot data; op_done 1 cycle after accept.
- TLBP with mmu_p_index = 0x80000000 -> Index reads 0x80000000 after done; repeat with 0x00000007 -> Index reads 7; done 2 cycles after accept.
- TLBR with MTC0 EntryLo0 = 0x55 during LOOKUP -> after CAPTURE, EntryLo0 = mmu_r_lo0; a same-cycle MTC0 in CAPTURE loses.
- exc_tlb with exc_badvaddr = 0x7FFFE123 during LOOKUP -> EntryHi.VPN2 = 0x3FFFF, Context[22:4] = 0x3FFFF, no op_done, FSM back in IDLE next cycle.
